spi_slot_arbiter: RTL and testbench
===================================

# spi_slot_arbiter

Shares the single host SPI link of the CPLD among NUM_SLOTS IO16-style card slots. Slots raise interrupt requests; the arbiter picks one round-robin, flags it to the host MCU with an interrupt and slot ID, then routes the host SPI lines to that slot for exactly one NSS-framed transfer. It replaces the fixed one-to-one SPI pass-through when more than one card hangs off the host port.

## Interface

- NUM_SLOTS, 4, number of slots, legal 2..8
- TIMEOUT_CYCLES, 50000, CLK cycles the host is allowed to wait before asserting NSS after a grant, legal 1..65535
- SW (localparam), $clog2(NUM_SLOTS), slot ID width
- CLK  input  1  system clock; all state is clocked on its rising edge
- RST  input  1  synchronous, active-high reset
- HOST_SPI_CLK_IN  input  1  host SCK, asynchronous to CLK
- HOST_SPI_MOSI_IN  input  1  host MOSI
- HOST_SPI_NSS_IN  input  1  host chip select, active low, asynchronous
- HOST_SPI_MISO_OUT  output  1  MISO of the granted slot, else 0
- HOST_INT_OUT  output  1  high while a grant awaits or is in service
- HOST_SLOT_ID_OUT  output  SW  ID of the granted slot
- BUSY_OUT  output  1  high in any state other than IDLE
- TIMEOUT_OUT  output  1  one-cycle pulse on grant timeout
- SLOT_SPI_CLK_OUT  output  NUM_SLOTS  per-slot SCK
- SLOT_SPI_MOSI_OUT  output  NUM_SLOTS  per-slot MOSI
- SLOT_SPI_NSS_OUT  output  NUM_SLOTS  per-slot NSS, active low
- SLOT_SPI_MISO_IN  input  NUM_SLOTS  per-slot MISO
- SLOT_SPI_INT_IN  input  NUM_SLOTS  per-slot request, active high, asynchronous

## Operation

- SLOT_SPI_INT_IN and HOST_SPI_NSS_IN each pass a 2-flop synchronizer (req_s, nss_s). SCK/MOSI/MISO are not synchronized; they are muxed combinationally under the registered grant.
- States: IDLE, GRANT, WAIT_NSS, XFER, RELEASE.
- IDLE: if any req_s bit is set and nss_s = 1, pick the first requesting slot scanning upward from rr_ptr, wrapping modulo NUM_SLOTS; register grant_id; go to GRANT. If nss_s = 0 (host framing with no grant), stay in IDLE; that frame is not forwarded.
- GRANT: one cycle; HOST_INT_OUT and HOST_SLOT_ID_OUT become valid; go to WAIT_NSS.
- WAIT_NSS: on nss_s = 0 go to XFER. On timeout go to RELEASE and pulse TIMEOUT_OUT.
- XFER: on nss_s = 1 go to RELEASE.
- RELEASE: one cycle; HOST_INT_OUT low; rr_ptr = grant_id + 1 (wraps to 0 at NUM_SLOTS); go to IDLE.
- Routing while state is GRANT, WAIT_NSS or XFER: SLOT_SPI_NSS_OUT[grant_id] = HOST_SPI_NSS_IN, SLOT_SPI_CLK_OUT[grant_id] = HOST_SPI_CLK_IN, SLOT_SPI_MOSI_OUT[grant_id] = HOST_SPI_MOSI_IN, HOST_SPI_MISO_OUT = SLOT_SPI_MISO_IN[grant_id]. All other slots get NSS = 1, CLK = 0, MOSI = 0. In IDLE and RELEASE every slot is parked and HOST_SPI_MISO_OUT = 0.
- A slot whose INT stays high after service re-arbitrates. It has lowest priority next round because rr_ptr has advanced past it.
- A request that drops before being picked is forgotten. A request that drops after the grant does not cancel the grant.

## Timing

- Reset values: state IDLE, rr_ptr 0, grant_id 0, HOST_INT_OUT 0, HOST_SLOT_ID_OUT 0, BUSY_OUT 0, TIMEOUT_OUT 0, all SLOT_SPI_NSS_OUT 1, all SLOT_SPI_CLK_OUT/MOSI_OUT 0, HOST_SPI_MISO_OUT 0.
- Request latency: INT_IN sampled high at edge t gives req_s high after edge t+1. IDLE decides at edge t+2. HOST_INT_OUT is high from edge t+3 onward.
- NSS latency: 2 CLK cycles in both directions. Grant_id never changes outside IDLE, so routing is stable across a whole NSS frame.
- After NSS rises: RELEASE at +3 cycles, IDLE at +4. Earliest next grant is at +5.
- Timeout counter: 16 bits, cleared on entry to WAIT_NSS. Expires when the count reaches TIMEOUT_CYCLES-1, so WAIT_NSS lasts exactly TIMEOUT_CYCLES cycles.
- Reset mid-XFER: on the next CLK edge all slot NSS go high and all other outputs take their reset values. The host frame is truncated.

## Configuration

- SPI_ARB_TIMEOUT_EN defined: WAIT_NSS watchdog is present as described.
- SPI_ARB_TIMEOUT_EN undefined: no counter is built. WAIT_NSS waits indefinitely for NSS. TIMEOUT_OUT is tied to 0.

## Test plan

- Single request: NUM_SLOTS=4, INT_IN[2] rises. Required: HOST_INT_OUT=1 and HOST_SLOT_ID_OUT=2 three cycles later. A 16-bit host frame 0xA55A appears only on slot 2. Slot 2 MISO 0x1234 is returned to the host. Other NSS stay 1. INT drops 3 cycles after NSS rises.
- Round-robin: INT_IN=4'b1011 held high. Required: successive grants 0, 1, 3, 0, 1, 3, each after one host frame.
- Host frames while IDLE: NSS pulsed low with INT_IN=0. Required: all slot NSS stay 1, MISO_OUT=0, BUSY_OUT=0. A request arriving during that frame is not granted until 2 cycles after NSS returns high.
- Timeout: with SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, grant slot 1 and never assert NSS. Required: TIMEOUT_OUT pulses exactly once, 100 cycles after entry to WAIT_NSS. State returns to IDLE. With INT_IN[1] still high and INT_IN[3] high, slot 3 is granted next.
- Reset mid-transfer: RST asserted for 1 cycle during XFER on slot 0. Required: the next edge shows SLOT_SPI_NSS_OUT=4'b1111, HOST_INT_OUT=0, and rr_ptr=0. Re-arbitration works normally afterwards.

Source files
------------

// File: rtl/spi_slot_arbiter.sv
// Round-robin arbiter that lends the single host SPI link to one card slot per NSS frame.
// Define SPI_ARB_TIMEOUT_EN to build the WAIT_NSS grant watchdog; otherwise WAIT_NSS waits forever.
module spi_slot_arbiter #(
  parameter  int unsigned NUM_SLOTS      = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 50000,
  localparam int unsigned SW             = $clog2(NUM_SLOTS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 HOST_SPI_CLK_IN,
  input  logic                 HOST_SPI_MOSI_IN,
  input  logic                 HOST_SPI_NSS_IN,
  output logic                 HOST_SPI_MISO_OUT,
  output logic                 HOST_INT_OUT,
  output logic [SW-1:0]        HOST_SLOT_ID_OUT,
  output logic                 BUSY_OUT,
  output logic                 TIMEOUT_OUT,
  output logic [NUM_SLOTS-1:0] SLOT_SPI_CLK_OUT,
  output logic [NUM_SLOTS-1:0] SLOT_SPI_MOSI_OUT,
  output logic [NUM_SLOTS-1:0] SLOT_SPI_NSS_OUT,
  input  logic [NUM_SLOTS-1:0] SLOT_SPI_MISO_IN,
  input  logic [NUM_SLOTS-1:0] SLOT_SPI_INT_IN
);

  localparam int unsigned CW = 16;

  if (NUM_SLOTS < 2 || NUM_SLOTS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("spi_slot_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT_NSS,
    XFER,
    RELEASE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_SLOTS-1:0] req_m;
  logic [NUM_SLOTS-1:0] req_s;
  logic                 nss_m;
  logic                 nss_s;
  logic [SW-1:0]        rr_ptr;
  logic [SW-1:0]        grant_id;
  logic [SW-1:0]        pick_id;
  logic [SW-1:0]        scan_id;
  int unsigned          scan_idx;
  logic                 pick_vld;
  logic                 timeout_hit;
  logic                 grant_load;
  logic                 host_int_nxt;
  logic                 busy_nxt;
  logic                 timeout_nxt;
  logic                 route_en;

  // Two-flop synchronizers for the asynchronous request and chip-select lines
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_m <= '0;
      req_s <= '0;
      nss_m <= 1'b1;
      nss_s <= 1'b1;
    end else begin
      req_m <= SLOT_SPI_INT_IN;
      req_s <= req_m;
      nss_m <= HOST_SPI_NSS_IN;
      nss_s <= nss_m;
    end
  end

  // First requesting slot at or above rr_ptr, wrapping modulo NUM_SLOTS
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    scan_idx = 0;
    scan_id  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      scan_idx = 32'(rr_ptr) + i;
      if (scan_idx >= NUM_SLOTS) scan_idx = scan_idx - NUM_SLOTS;
      scan_id = SW'(scan_idx);
      if (!pick_vld && req_s[scan_id]) begin
        pick_vld = 1'b1;
        pick_id  = scan_id;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [CW-1:0] wait_cnt;

  // Counts cycles spent in WAIT_NSS; zero everywhere else so entry starts from 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (state == WAIT_NSS) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_hit = (state == WAIT_NSS) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timeout_nxt = 1'b0;
    grant_load  = 1'b0;
    case (state)
      IDLE: begin
        // A host frame already in progress without a grant is never forwarded
        if (pick_vld && nss_s) begin
          state_nxt  = GRANT;
          grant_load = 1'b1;
        end
      end
      GRANT:    state_nxt = WAIT_NSS;
      WAIT_NSS: begin
        if (!nss_s) begin
          state_nxt = XFER;
        end else if (timeout_hit) begin
          state_nxt   = RELEASE;
          timeout_nxt = 1'b1;
        end
      end
      XFER:     if (nss_s) state_nxt = RELEASE;
      RELEASE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    host_int_nxt = (state_nxt == WAIT_NSS) || (state_nxt == XFER);
    busy_nxt     = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr           <= '0;
      grant_id         <= '0;
      HOST_INT_OUT     <= 1'b0;
      HOST_SLOT_ID_OUT <= '0;
      BUSY_OUT         <= 1'b0;
      TIMEOUT_OUT      <= 1'b0;
    end else begin
      if (grant_load) grant_id <= pick_id;
      // Serviced slot drops to lowest priority for the next round
      if (state == RELEASE) begin
        rr_ptr <= (grant_id == SW'(NUM_SLOTS - 1)) ? '0 : grant_id + SW'(1);
      end
      HOST_INT_OUT     <= host_int_nxt;
      HOST_SLOT_ID_OUT <= grant_id;
      BUSY_OUT         <= busy_nxt;
      TIMEOUT_OUT      <= timeout_nxt;
    end
  end

  assign route_en = (state == GRANT) || (state == WAIT_NSS) || (state == XFER);

  // SCK/MOSI/MISO/NSS follow the host pins combinationally; only the grant is registered
  always_comb begin
    SLOT_SPI_NSS_OUT  = '1;
    SLOT_SPI_CLK_OUT  = '0;
    SLOT_SPI_MOSI_OUT = '0;
    HOST_SPI_MISO_OUT = 1'b0;
    if (route_en) begin
      SLOT_SPI_NSS_OUT[grant_id]  = HOST_SPI_NSS_IN;
      SLOT_SPI_CLK_OUT[grant_id]  = HOST_SPI_CLK_IN;
      SLOT_SPI_MOSI_OUT[grant_id] = HOST_SPI_MOSI_IN;
      HOST_SPI_MISO_OUT           = SLOT_SPI_MISO_IN[grant_id];
    end
  end

endmodule

// File: tb/tb_spi_slot_arbiter.sv
// Self-checking bench for spi_slot_arbiter (NUM_SLOTS=4, TIMEOUT_CYCLES=100).
// Expected grants come from a round-robin reference model; SPI traffic is bit-banged by the host side.
module tb_spi_slot_arbiter;

  localparam int NS = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_sck;
  logic          host_mosi;
  logic          host_nss;
  logic          host_miso;
  logic          host_int;
  logic [1:0]    host_id;
  logic          busy;
  logic          tmo;
  logic [NS-1:0] slot_sck;
  logic [NS-1:0] slot_mosi;
  logic [NS-1:0] slot_nss;
  logic [NS-1:0] slot_miso;
  logic [NS-1:0] slot_int;

  int checks   = 0;
  int failures = 0;
  int ptr      = 0;

  always #5 clk = ~clk;

  spi_slot_arbiter #(
    .NUM_SLOTS      (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK               (clk),
    .RST               (rst),
    .HOST_SPI_CLK_IN   (host_sck),
    .HOST_SPI_MOSI_IN  (host_mosi),
    .HOST_SPI_NSS_IN   (host_nss),
    .HOST_SPI_MISO_OUT (host_miso),
    .HOST_INT_OUT      (host_int),
    .HOST_SLOT_ID_OUT  (host_id),
    .BUSY_OUT          (busy),
    .TIMEOUT_OUT       (tmo),
    .SLOT_SPI_CLK_OUT  (slot_sck),
    .SLOT_SPI_MOSI_OUT (slot_mosi),
    .SLOT_SPI_NSS_OUT  (slot_nss),
    .SLOT_SPI_MISO_IN  (slot_miso),
    .SLOT_SPI_INT_IN   (slot_int)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester scanning upward from ptr, modulo NS
  function automatic int rr_pick(input logic [NS-1:0] mask, input int p);
    for (int i = 0; i < NS; i++) begin
      if (mask[(p + i) % NS]) return (p + i) % NS;
    end
    return -1;
  endfunction

  task automatic serve_grant(input int exp_id, input string tag);
    int n = 0;
    while (host_int !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_int"}, 32'(host_int), 1);
    check({tag, "_id"}, 32'(host_id), 32'(exp_id));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  // One 16-bit mode-0 host frame; slot id echoes miso, noise on every other slot MISO
  task automatic host_frame(input int id, input logic [15:0] tx, input logic [15:0] miso);
    logic [15:0]   slot_rx;
    logic [15:0]   host_rx;
    logic [NS-1:0] sel;
    int            err;
    sel     = NS'(1 << id);
    slot_rx = '0;
    host_rx = '0;
    err     = 0;
    #1 host_nss = 1'b0;
    #20;
    for (int b = 15; b >= 0; b--) begin
      host_mosi     = tx[b];
      slot_miso     = NS'($urandom);
      slot_miso[id] = miso[b];
      #5 host_sck = 1'b1;
      #1;
      if (slot_sck !== sel) err++;
      if (slot_nss !== ~sel) err++;
      if ((slot_mosi & ~sel) !== '0) err++;
      slot_rx = {slot_rx[14:0], slot_mosi[id]};
      host_rx = {host_rx[14:0], host_miso};
      #4 host_sck = 1'b0;
    end
    #10 host_nss = 1'b1;
    check("frame_route", 32'(err), 0);
    check("frame_slot_rx", 32'(slot_rx), 32'(tx));
    check("frame_host_rx", 32'(host_rx), 32'(miso));
  endtask

  initial begin
    int            e;
    int            mask;
    int            nxt;
    int            err;
    int            pulses;
    int            pulse_at;

    rst       = 1'b1;
    host_sck  = 1'b0;
    host_mosi = 1'b0;
    host_nss  = 1'b1;
    slot_miso = '1;
    slot_int  = '0;
    tick();
    tick();
    check("rst_int", 32'(host_int), 0);
    check("rst_id", 32'(host_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tmo", 32'(tmo), 0);
    check("rst_nss", 32'(slot_nss), 32'hF);
    check("rst_sck", 32'(slot_sck), 0);
    check("rst_mosi", 32'(slot_mosi), 0);
    check("rst_miso", 32'(host_miso), 0);
    rst = 1'b0;
    repeat (3) tick();

    // Round-robin with 1011 held: expected 0,1,3,0,1,3
    slot_int = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      e = rr_pick(4'b1011, ptr);
      serve_grant(e, "rr");
      if (k == 5) slot_int = '0;
      host_frame(e, 16'($urandom), 16'($urandom));
      wait_idle("rr");
      ptr = (e + 1) % NS;
    end
    repeat (4) tick();
    check("rr_quiet", 32'(busy), 0);

    // Single request on slot 2 with exact latencies
    #1 slot_int = 4'b0100;
    tick();
    check("req_e1_int", 32'(host_int), 0);
    tick();
    check("req_e2_busy", 32'(busy), 0);
    tick();
    check("req_e3_busy", 32'(busy), 1);
    check("req_e3_int", 32'(host_int), 0);
    tick();
    check("req_e4_int", 32'(host_int), 1);
    check("req_e4_id", 32'(host_id), 2);
    slot_int = '0;
    host_frame(2, 16'hA55A, 16'h1234);
    tick();
    check("drop_e1_int", 32'(host_int), 1);
    tick();
    check("drop_e2_int", 32'(host_int), 1);
    tick();
    check("drop_e3_int", 32'(host_int), 0);
    check("drop_e3_busy", 32'(busy), 1);
    tick();
    check("drop_e4_busy", 32'(busy), 0);
    ptr = 3;
    repeat (3) tick();

    // Random request patterns against the model; the next mask is applied mid-service
    mask     = $urandom_range(1, 15);
    slot_int = NS'(mask);
    for (int r = 0; r < 12; r++) begin
      e = rr_pick(NS'(mask), ptr);
      serve_grant(e, "rand");
      nxt      = (r == 11) ? 0 : int'($urandom_range(1, 15));
      slot_int = NS'(nxt);
      host_frame(e, 16'($urandom), 16'($urandom));
      wait_idle("rand");
      ptr  = (e + 1) % NS;
      mask = nxt;
    end
    repeat (4) tick();
    check("rand_quiet", 32'(busy), 0);

    // Host framing while IDLE is not forwarded; a request during it waits for NSS high
    #1 host_nss = 1'b0;
    host_sck  = 1'b1;
    host_mosi = 1'b1;
    slot_miso = '1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 5) slot_int = 4'b0100;
      err = 0;
      if (slot_nss !== 4'hF) err++;
      if (host_miso !== 1'b0) err++;
      if (slot_sck !== 4'h0) err++;
      if (slot_mosi !== 4'h0) err++;
      check("idle_frame_parked", 32'(err), 0);
      check("idle_frame_busy", 32'(busy), 0);
    end
    host_sck  = 1'b0;
    host_mosi = 1'b0;
    #1 host_nss = 1'b1;
    tick();
    check("nss_hi_e1_busy", 32'(busy), 0);
    tick();
    check("nss_hi_e2_busy", 32'(busy), 0);
    tick();
    check("nss_hi_e3_busy", 32'(busy), 1);
    tick();
    check("nss_hi_e4_int", 32'(host_int), 1);
    check("nss_hi_e4_id", 32'(host_id), 2);
    slot_int = '0;
    host_frame(2, 16'($urandom), 16'($urandom));
    wait_idle("idle_frame");
    ptr = 3;
    repeat (3) tick();

    // Grant slot 1 and never assert NSS
    slot_int = 4'b0010;
    serve_grant(rr_pick(4'b0010, ptr), "tmo_grant");
    slot_int = 4'b1010;
    pulses   = 0;
    pulse_at = -1;
`ifdef SPI_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO + 10; k++) begin
      tick();
      if (tmo === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = k;
      end
      if (k == TO - 1) check("tmo_int_held", 32'(host_int), 1);
      if (k == TO) check("tmo_int_drop", 32'(host_int), 0);
    end
    check("tmo_pulses", 32'(pulses), 1);
    check("tmo_pulse_at", 32'(pulse_at), 32'(TO));
    check("tmo_idle", 32'(busy), 0);
    ptr = 2;
`else
    for (int k = 1; k <= TO + 10; k++) begin
      tick();
      if (tmo === 1'b1) pulses++;
    end
    check("notmo_pulses", 32'(pulses), 0);
    check("notmo_still_waiting", 32'(host_int), 1);
    host_frame(1, 16'($urandom), 16'($urandom));
    wait_idle("notmo");
    ptr = 2;
`endif
    serve_grant(rr_pick(4'b1010, ptr), "after_tmo");
    slot_int = 4'b0010;
    host_frame(3, 16'($urandom), 16'($urandom));
    wait_idle("after_tmo");
    ptr = 0;

    serve_grant(rr_pick(4'b0010, ptr), "pre_rst1");
    slot_int = 4'b0001;
    host_frame(1, 16'($urandom), 16'($urandom));
    wait_idle("pre_rst1");
    ptr = 2;

    // Reset in the middle of an XFER on slot 0
    serve_grant(rr_pick(4'b0001, ptr), "pre_rst0");
    slot_int = '0;
    #1 host_nss = 1'b0;
    repeat (5) tick();
    slot_miso = '1;
    check("xfer_busy", 32'(busy), 1);
    check("xfer_nss_routed", 32'(slot_nss), 32'hE);
    #1 rst = 1'b1;
    tick();
    check("mid_rst_nss", 32'(slot_nss), 32'hF);
    check("mid_rst_int", 32'(host_int), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_id", 32'(host_id), 0);
    check("mid_rst_tmo", 32'(tmo), 0);
    check("mid_rst_miso", 32'(host_miso), 0);
    rst      = 1'b0;
    host_nss = 1'b1;
    ptr      = 0;
    slot_int = 4'b0101;
    serve_grant(rr_pick(4'b0101, ptr), "post_rst");
    slot_int = '0;
    host_frame(0, 16'($urandom), 16'($urandom));
    wait_idle("post_rst");
    repeat (4) tick();
    check("final_quiet", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
